// File: rtl/dadda_reduce_pipe_if.sv
// Operand/result handshake bundle for the Dadda reduction pipeline.
// The slave side is the pipeline; the master side is the producer/consumer.
interface dadda_reduce_pipe_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a;
  logic [15:0]      b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      sum_row;
  logic [31:0]      carry_row;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, sum_row, carry_row, out_tag
  );

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, sum_row, carry_row, out_tag
  );
endinterface

// File: rtl/dadda_reduce_pipe.sv
// 16x16 unsigned Dadda partial-product tree, two register stages:
// heights 16 -> 13 -> 9 -> 6 into s1, then 6 -> 4 -> 3 -> 2 into s2.
module dadda_reduce_pipe #(
  parameter int TAG_W = 4
) (
  input logic               clk,
  input logic               rst,
  dadda_reduce_pipe_if.slave bus
);

  // Column set: bits[col][k] is valid for k < ht[col]; heights are data-independent.
  typedef struct packed {
    logic [31:0][15:0] bits;
    logic [31:0][4:0]  ht;
  } cols_t;

  function automatic cols_t pp_array(input logic [15:0] a, input logic [15:0] b);
    cols_t c;
    int    w;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        w = int'(c.ht[i+j]);
        c.bits[i+j][w] = a[i] & b[j];
        c.ht[i+j]      = c.ht[i+j] + 5'd1;
      end
    end
    return c;
  endfunction

  // One Dadda level: per column, excess >= 2 takes a full adder, excess == 1 a half adder.
  function automatic cols_t dadda_step(input cols_t c, input int d);
    cols_t n;
    int    p;
    int    ex;
    int    w;
    int    ip;
    logic  s;
    logic  co;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      p  = 0;
      ip = (i < 31) ? i + 1 : 31;
      ex = int'(c.ht[i]) + int'(n.ht[i]) - d;
      for (int k = 0; k < 8; k++) begin
        if (ex >= 1) begin
          if (ex >= 2) begin
            s  = c.bits[i][p] ^ c.bits[i][p+1] ^ c.bits[i][p+2];
            co = (c.bits[i][p] & c.bits[i][p+1]) | (c.bits[i][p] & c.bits[i][p+2]) |
                 (c.bits[i][p+1] & c.bits[i][p+2]);
            p  = p + 3;
            ex = ex - 2;
          end else begin
            s  = c.bits[i][p] ^ c.bits[i][p+1];
            co = c.bits[i][p] & c.bits[i][p+1];
            p  = p + 2;
            ex = ex - 1;
          end
          w             = int'(n.ht[i]);
          n.bits[i][w]  = s;
          n.ht[i]       = n.ht[i] + 5'd1;
          // Carry out of column 31 always has zero value since a*b < 2^32.
          if (i < 31) begin
            w             = int'(n.ht[ip]);
            n.bits[ip][w] = co;
            n.ht[ip]      = n.ht[ip] + 5'd1;
          end
        end
      end
      for (int q = 0; q < 16; q++) begin
        if (q >= p && q < int'(c.ht[i])) begin
          w            = int'(n.ht[i]);
          n.bits[i][w] = c.bits[i][q];
          n.ht[i]      = n.ht[i] + 5'd1;
        end
      end
    end
    return n;
  endfunction

  function automatic cols_t stage1(input logic [15:0] a, input logic [15:0] b);
    return dadda_step(dadda_step(dadda_step(pp_array(a, b), 13), 9), 6);
  endfunction

  function automatic logic [31:0][15:0] bits_of(input cols_t c);
    return c.bits;
  endfunction

  // Only the bits of s1 are registered; the column heights are constants.
  function automatic cols_t with_s1_heights(input logic [31:0][15:0] bits);
    cols_t c;
    c      = stage1(16'h0, 16'h0);
    c.bits = bits;
    return c;
  endfunction

  function automatic logic [63:0] rows_of(input cols_t c);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i]      = c.bits[i][0];
      r[i + 32] = c.bits[i][1];
    end
    return r;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [31:0][15:0] s1_bits_q, s1_bits_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_sum_q, s2_sum_d;
  logic [31:0]       s2_carry_q, s2_carry_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic              s1_adv;
  logic              s2_adv;

  always_comb begin
    s2_adv     = !s2_valid_q || bus.out_ready;
    s1_adv     = !s1_valid_q || s2_adv;

    s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
    s1_bits_d  = s1_bits_q;
    s1_tag_d   = s1_tag_q;
    if (s1_adv && bus.in_valid) begin
      s1_bits_d = bits_of(stage1(bus.a, bus.b));
      s1_tag_d  = bus.in_tag;
    end

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_carry_d = s2_carry_q;
    s2_tag_d   = s2_tag_q;
    if (s2_adv && s1_valid_q) begin
      {s2_carry_d, s2_sum_d} = rows_of(dadda_step(dadda_step(dadda_step(
                                 with_s1_heights(s1_bits_q), 4), 3), 2));
      s2_tag_d               = s1_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_bits_q  <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_bits_q  <= s1_bits_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_carry_q <= s2_carry_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.sum_row   = s2_sum_q;
  assign bus.carry_row = s2_carry_q;
  assign bus.out_tag   = s2_tag_q;

endmodule

// File: tb/tb_dadda_reduce_pipe.sv
// Scoreboard bench for dadda_reduce_pipe: driver pushes expected products,
// negedge monitor pops on each output transfer and checks stall stability.
module tb_dadda_reduce_pipe;
  localparam int TAG_W = 4;

  typedef struct {
    logic [32:0]      prod;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dadda_reduce_pipe_if #(.TAG_W(TAG_W)) bus ();
  dadda_reduce_pipe #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor
  logic             prev_stall = 1'b0;
  logic [31:0]      p_sum, p_car;
  logic [TAG_W-1:0] p_tag;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {bus.out_valid, bus.sum_row, bus.carry_row, bus.out_tag},
            {1'b1, p_sum, p_car, p_tag});
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 96'd1, 96'd0);
        end else begin
          e = sb_q.pop_front();
          chk("row_sum", {1'b0, bus.sum_row} + {1'b0, bus.carry_row}, e.prod);
          chk("out_tag", bus.out_tag, e.tag);
        end
      end
      prev_stall <= bus.out_valid && !bus.out_ready;
      p_sum      <= bus.sum_row;
      p_car      <= bus.carry_row;
      p_tag      <= bus.out_tag;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [TAG_W-1:0] tag, input logic [32:0] prod);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.in_tag   = tag;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        e.prod = prod;
        e.tag  = tag;
        sb_q.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 96'd0, 96'd1);
  endtask

  task automatic send_rand();
    logic [15:0] a, b;
    logic [TAG_W-1:0] t;
    a = 16'($urandom);
    b = 16'($urandom);
    t = TAG_W'($urandom);
    send(a, b, t, {17'd0, a} * {17'd0, b});
  endtask

  task automatic drain();
    for (int n = 0; n < 50; n++) begin
      if (sb_q.size() == 0 && !bus.out_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", 96'(sb_q.size()), 96'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  // Directed corner vectors: a, b, tag, hand-computed product
  logic [15:0] dir_a [3] = '{16'hFFFF, 16'h0000, 16'h0001};
  logic [15:0] dir_b [3] = '{16'hFFFF, 16'h1234, 16'h8001};
  logic [3:0]  dir_t [3] = '{4'd3, 4'd4, 4'd5};
  logic [32:0] dir_p [3] = '{33'h0FFFE0001, 33'h0, 33'h000008001};

  initial begin
    int t0;
    int endc;
    logic done;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h0005;
    bus.b         = 16'h0007;
    bus.in_tag    = 4'd1;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_rows", {bus.sum_row, bus.carry_row}, 64'd0);
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Latency on the all-ones corner
    send(dir_a[0], dir_b[0], dir_t[0], dir_p[0]);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("latency_k1_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("latency_k2_valid", bus.out_valid, 1'b1);
    @(posedge clk); #1;
    for (int i = 1; i < 3; i++) send(dir_a[i], dir_b[i], dir_t[i], dir_p[i]);
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back streaming
    t0 = cyc;
    for (int i = 0; i < 100; i++) send_rand();
    chk("stream_rate_cycles", 96'(cyc - t0), 96'd100);
    bus.in_valid = 1'b0;
    drain();

    // Back-pressure window of 5 cycles
    fork
      begin
        for (int i = 0; i < 20; i++) send_rand();
        bus.in_valid = 1'b0;
      end
      begin
        repeat (6) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i == 4) chk("bp_in_ready", bus.in_ready, 1'b0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight
    bus.out_ready = 1'b0;
    send(16'd3, 16'd3, 4'd9, 33'd9);
    send(16'd4, 16'd4, 4'd10, 33'd16);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flight_full_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_rows", {bus.sum_row, bus.carry_row}, 64'd0);
    @(posedge clk); #1;
    send(16'd7, 16'd9, 4'd5, 33'd63);
    bus.in_valid = 1'b0;
    drain();

    // Random valid/ready toggling
    endc = cyc + 10000;
    done = 1'b0;
    fork
      begin
        while (cyc < endc) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
          end else begin
            send_rand();
          end
        end
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dadda_reduce_pipe.md
Name: dadda_reduce_pipe

Overview:
- Pipelined 16x16 unsigned Dadda partial-product generator and reduction tree.
- Collapses 16 partial-product rows to two 32-bit rows (sum_row, carry_row). These feed the 32-bit Brent-Kung final adder directly, with adder cin tied 0.
- Two register stages with valid/ready handshake on both sides. Sustains one multiply per cycle when not back-pressured.

Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each operand pair (legal range 1..16).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operands this cycle
- a  input  16  multiplicand, unsigned
- b  input  16  multiplier, unsigned
- in_tag  input  TAG_W  opaque tag
- out_valid  output  1  reduced rows present
- out_ready  input  1  downstream (final adder) accepts
- sum_row  output  32  first reduced row
- carry_row  output  32  second reduced row
- out_tag  output  TAG_W  tag of the transaction in sum_row/carry_row

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: every register clears at the rising edge while rst=1. This includes s1_valid, s2_valid, all data and tag registers, and outputs (out_valid=0, sum_row=0, carry_row=0, out_tag=0). rst overrides all handshakes.
- Handshake: a transfer occurs on an edge where valid&ready=1.
  - in_valid, a, b and in_tag must be held stable until accepted.
- Stage 1, combinational on inputs, registered into s1:
  - AND-array generates 256 partial-product bits.
  - Dadda reduction with column-height targets 13, 9, 6, using full adders (3:2) and half adders (2:2).
  - Registers the resulting height-6 column set and the tag.
- Stage 2, combinational on s1, registered into s2:
  - Reduction with targets 4, 3, 2.
  - Registers the two rows as sum_row and carry_row, plus the tag.
  - sum_row, carry_row and out_tag are driven directly from s2 registers; no combinational path from inputs to outputs.
- Pipeline control:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
  - in_ready depends combinationally on out_ready; this is the only such path.
  - s1 loads on in_valid&in_ready; s1_valid <= in_valid when s1_adv, else holds.
  - s2 loads from s1 when s2_adv; s2_valid <= s1_valid when s2_adv, else holds.
- Latency: an operand pair accepted at edge k appears with out_valid=1 after edge k+2, provided no stall.
- Throughput: 1 per cycle with out_ready held 1.
- Stall: while out_valid=1 and out_ready=0, sum_row, carry_row and out_tag hold bit-stable.
  - s1 may still fill once, then in_ready=0.
  - At most 2 transactions are in flight.
  - No transaction is dropped or duplicated.
- Bubbles: out_valid=0 gaps propagate unchanged. Row values while out_valid=0 are don't-care, except after reset, where they are 0.
- Arithmetic invariant, checked at every output transfer: sum_row + carry_row (32-bit unsigned, no wrap) == a*b of that transaction.
  - The true sum never exceeds 32'hFFFE0001, so final-adder cout is always 0.
  - The bit-level split between the two rows is implementation-defined, but must be a deterministic function of (a, b).
- Ordering: strictly in order; out_tag equals the in_tag captured with the same operands.
- Simultaneous events: with s2 full, out_ready=1 and s1 full, s2 drains, s1 moves to s2 and a new input enters s1, all on the same edge.
- Reset mid-operation: all in-flight transactions are discarded. The first post-reset output is from the first operand pair accepted after rst deasserts.
- Synthesis: no latches, no X on outputs after reset, single clock domain.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, sum_row=carry_row=0 throughout; in_ready=1 on the first cycle after rst=0.
- Corners: a=0xFFFF, b=0xFFFF, tag=3 -> 2 edges later out_valid=1, sum_row+carry_row=0xFFFE0001, out_tag=3. Also a=0, b=0x1234 -> sum 0; a=1, b=0x8001 -> sum 0x00008001.
- Streaming: 100 back-to-back random pairs with out_ready=1 -> one output per cycle, in order, every row-sum == a*b, tags match.
- Back-pressure: out_ready=0 for 5 cycles while streaming -> outputs frozen and in_ready=0 once s1 is full; on release, all transactions emerge in order with none lost.
- Reset mid-flight: 2 transactions in flight, assert rst for 1 cycle -> neither emerges; the next accepted pair (a=7, b=9) yields a row-sum of 63.
- Random: random valid/ready toggling over 10k cycles against a scoreboard -> zero mismatches; outputs stable while stalled.
